// File: rtl/hpd_monitor.sv
// ============================================================================
// Module   : hpd_monitor
// Summary  : Hot-plug detect monitor with plug/unplug qualification and
//            IRQ low-pulse classification, spacing and pending-IRQ tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hpd_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int PLUG_TICKS    = 100,
    parameter int UNPLUG_TICKS  = 200,
    parameter int IRQ_MIN_TICKS = 50,
    parameter int IRQ_MAX_TICKS = 100,
    parameter int SPACING_TICKS = 200,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hpd_signal,
    input  logic             irq_en,
    input  logic             irq_ack,
    output logic             hpd_detect,
    output logic             hpd_irq,
    output logic             plug_event,
    output logic             unplug_event,
    output logic             irq_dropped,
    output logic             bad_pulse,
    output logic [CNT_W-1:0] irq_count
);

    localparam logic [31:0] C_PLUG    = 32'(PLUG_TICKS);
    localparam logic [31:0] C_UNPLUG  = 32'(UNPLUG_TICKS);
    localparam logic [31:0] C_IRQ_MIN = 32'(IRQ_MIN_TICKS);
    localparam logic [31:0] C_IRQ_MAX = 32'(IRQ_MAX_TICKS);
    localparam logic [31:0] C_SPACING = 32'(SPACING_TICKS);

    typedef enum logic [1:0] {
        S_DISCONNECTED = 2'd0,
        S_PLUG_QUAL    = 2'd1,
        S_CONNECTED    = 2'd2,
        S_LOW_MEAS     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_hpd_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_cnt;
    logic [31:0]            w_cnt_nxt;
    logic [31:0]            w_cnt_inc;
    logic [31:0]            r_spcnt;
    logic [31:0]            w_spcnt_nxt;

    logic                   r_detect;
    logic                   w_detect_nxt;
    logic                   r_irq;
    logic                   w_irq_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   r_plug;
    logic                   w_plug_nxt;
    logic                   r_unplug;
    logic                   w_unplug_nxt;
    logic                   r_dropped;
    logic                   w_dropped_nxt;
    logic                   r_bad;
    logic                   w_bad_nxt;

    assign w_hpd_s   = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + 32'd1;

    // Next-state logic. cnt holds the number of hpd_s cycles already spent at
    // the level being measured, so a threshold fires on the cycle the level
    // has been seen for exactly that many cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_spcnt_nxt   = (r_spcnt < C_SPACING) ? (r_spcnt + 32'd1) : C_SPACING;
        w_detect_nxt  = r_detect;
        w_irq_nxt     = irq_ack ? 1'b0 : r_irq;
        w_count_nxt   = r_count;
        w_plug_nxt    = 1'b0;
        w_unplug_nxt  = 1'b0;
        w_dropped_nxt = 1'b0;
        w_bad_nxt     = 1'b0;

        case (r_state)
            S_DISCONNECTED: begin
                w_cnt_nxt = 32'd0;
                if (w_hpd_s) begin
                    w_state_nxt = S_PLUG_QUAL;
                    w_cnt_nxt   = 32'd1;
                end
            end

            S_PLUG_QUAL: begin
                if (!w_hpd_s) begin
                    w_state_nxt = S_DISCONNECTED;
                    w_cnt_nxt   = 32'd0;
                end else if (w_cnt_inc >= C_PLUG) begin
                    w_state_nxt  = S_CONNECTED;
                    w_cnt_nxt    = 32'd0;
                    w_detect_nxt = 1'b1;
                    w_plug_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_CONNECTED: begin
                w_cnt_nxt = 32'd0;
                if (!w_hpd_s) begin
                    w_state_nxt = S_LOW_MEAS;
                    w_cnt_nxt   = 32'd1;
                end
            end

            S_LOW_MEAS: begin
                if (!w_hpd_s) begin
                    if (w_cnt_inc >= C_UNPLUG) begin
                        w_state_nxt  = S_DISCONNECTED;
                        w_cnt_nxt    = 32'd0;
                        w_detect_nxt = 1'b0;
                        w_irq_nxt    = 1'b0;
                        w_unplug_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    // Rising edge: r_cnt is the exact low-pulse length.
                    w_state_nxt = S_CONNECTED;
                    w_cnt_nxt   = 32'd0;
                    if (r_cnt > C_IRQ_MAX) begin
                        w_bad_nxt = 1'b1;
                    end else if (r_cnt >= C_IRQ_MIN) begin
                        if (irq_en && (r_spcnt >= C_SPACING)) begin
                            w_irq_nxt   = 1'b1;
                            w_spcnt_nxt = 32'd0;
                            if (r_count != {CNT_W{1'b1}}) begin
                                w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            w_dropped_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_DISCONNECTED;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_state   <= S_DISCONNECTED;
            r_cnt     <= 32'd0;
            r_spcnt   <= C_SPACING;
            r_detect  <= 1'b0;
            r_irq     <= 1'b0;
            r_count   <= '0;
            r_plug    <= 1'b0;
            r_unplug  <= 1'b0;
            r_dropped <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], hpd_signal};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_spcnt   <= w_spcnt_nxt;
            r_detect  <= w_detect_nxt;
            r_irq     <= w_irq_nxt;
            r_count   <= w_count_nxt;
            r_plug    <= w_plug_nxt;
            r_unplug  <= w_unplug_nxt;
            r_dropped <= w_dropped_nxt;
            r_bad     <= w_bad_nxt;
        end
    end

    assign hpd_detect   = r_detect;
    assign hpd_irq      = r_irq;
    assign irq_count    = r_count;
    assign plug_event   = r_plug;
    assign unplug_event = r_unplug;
    assign irq_dropped  = r_dropped;
    assign bad_pulse    = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_hpd_monitor.sv
// ============================================================================
// Module   : tb_hpd_monitor
// Summary  : Directed self-checking bench for hpd_monitor (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hpd_monitor;

    logic        clk;
    logic        rst_n;
    logic        hpd_signal;
    logic        irq_en;
    logic        irq_ack;
    logic        hpd_detect;
    logic        hpd_irq;
    logic        plug_event;
    logic        unplug_event;
    logic        irq_dropped;
    logic        bad_pulse;
    logic [15:0] irq_count;

    int n_tests = 0;
    int n_fail  = 0;

    int n_plug   = 0;
    int n_unplug = 0;
    int n_drop   = 0;
    int n_bad    = 0;
    int n_multi  = 0;

    hpd_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hpd_signal   (hpd_signal),
        .irq_en       (irq_en),
        .irq_ack      (irq_ack),
        .hpd_detect   (hpd_detect),
        .hpd_irq      (hpd_irq),
        .plug_event   (plug_event),
        .unplug_event (unplug_event),
        .irq_dropped  (irq_dropped),
        .bad_pulse    (bad_pulse),
        .irq_count    (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse-cycle tally; a pulse held longer than one cycle inflates its count.
    always @(negedge clk) begin
        n_plug   += int'(plug_event);
        n_unplug += int'(unplug_event);
        n_drop   += int'(irq_dropped);
        n_bad    += int'(bad_pulse);
        if ((int'(plug_event) + int'(unplug_event) + int'(irq_dropped) + int'(bad_pulse)) > 1)
            n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic low_pulse(input int len);
        hpd_signal = 1'b0;
        tick(len);
        hpd_signal = 1'b1;
        tick(10);
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_detect"}, 32'(hpd_detect), 32'd0);
        check({tag, "_irq"},    32'(hpd_irq),    32'd0);
        check({tag, "_count"},  32'(irq_count),  32'd0);
        check({tag, "_pulses"}, 32'({plug_event, unplug_event, irq_dropped, bad_pulse}), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        hpd_signal = 1'b0;
        irq_en     = 1'b0;
        irq_ack    = 1'b0;
        tick(5);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // Short high burst must not qualify a plug.
        hpd_signal = 1'b1;
        tick(60);
        hpd_signal = 1'b0;
        tick(20);
        @(negedge clk);
        check("short_plug_events", 32'(n_plug), 32'd0);
        check("short_plug_detect", 32'(hpd_detect), 32'd0);

        // Plug: detect rises on the 102nd edge after the pin goes high.
        hpd_signal = 1'b1;
        tick(101);
        @(negedge clk);
        check("plug_before_edge", 32'(hpd_detect), 32'd0);
        tick(1);
        @(negedge clk);
        check("plug_detect_edge", 32'(hpd_detect), 32'd1);
        check("plug_event_edge",  32'(plug_event), 32'd1);
        tick(48);
        @(negedge clk);
        check("plug_events", 32'(n_plug), 32'd1);

        // Single IRQ and acknowledge.
        irq_en = 1'b1;
        low_pulse(75);
        @(negedge clk);
        check("irq_pending", 32'(hpd_irq),   32'd1);
        check("irq_count1",  32'(irq_count), 32'd1);
        tick(1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        @(negedge clk);
        check("irq_ack_clear", 32'(hpd_irq), 32'd0);
        tick(1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        @(negedge clk);
        check("ack_noop_irq",   32'(hpd_irq),   32'd0);
        check("ack_noop_count", 32'(irq_count), 32'd1);

        // Spacing: 100 apart -> second dropped; 250 apart -> both accepted.
        tick(250);
        low_pulse(75);
        tick(90);
        low_pulse(75);
        @(negedge clk);
        check("spacing_close_count", 32'(irq_count), 32'd2);
        check("spacing_close_drop",  32'(n_drop),    32'd1);
        tick(250);
        low_pulse(75);
        tick(240);
        low_pulse(75);
        @(negedge clk);
        check("spacing_far_count", 32'(irq_count), 32'd4);
        check("spacing_far_drop",  32'(n_drop),    32'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;

        // Boundary pulse lengths, spacing satisfied before each.
        tick(250);
        low_pulse(49);
        @(negedge clk);
        check("len49_count", 32'(irq_count), 32'd4);
        check("len49_bad",   32'(n_bad),     32'd0);
        tick(250);
        low_pulse(50);
        @(negedge clk);
        check("len50_count", 32'(irq_count), 32'd5);
        tick(250);
        low_pulse(100);
        @(negedge clk);
        check("len100_count", 32'(irq_count), 32'd6);
        check("len100_bad",   32'(n_bad),     32'd0);
        tick(250);
        low_pulse(101);
        @(negedge clk);
        check("len101_count", 32'(irq_count), 32'd6);
        check("len101_bad",   32'(n_bad),     32'd1);
        tick(250);
        low_pulse(199);
        @(negedge clk);
        check("len199_bad",    32'(n_bad),      32'd2);
        check("len199_unplug", 32'(n_unplug),   32'd0);
        check("len199_detect", 32'(hpd_detect), 32'd1);

        // Candidate with IRQs disabled is dropped.
        irq_en = 1'b0;
        tick(250);
        low_pulse(75);
        @(negedge clk);
        check("disabled_drop",  32'(n_drop),    32'd2);
        check("disabled_count", 32'(irq_count), 32'd6);
        irq_en = 1'b1;

        // Unplug with an IRQ still pending.
        check("pre_unplug_irq", 32'(hpd_irq), 32'd1);
        hpd_signal = 1'b0;
        tick(210);
        @(negedge clk);
        check("unplug_event",  32'(n_unplug),   32'd1);
        check("unplug_detect", 32'(hpd_detect), 32'd0);
        check("unplug_irq",    32'(hpd_irq),    32'd0);

        // Reset in the middle of a low pulse.
        hpd_signal = 1'b1;
        tick(150);
        @(negedge clk);
        check("replug_detect", 32'(hpd_detect), 32'd1);
        hpd_signal = 1'b0;
        tick(40);
        rst_n = 1'b0;
        tick(3);
        check_all_zero("midpulse_reset");
        rst_n = 1'b1;
        tick(32);
        hpd_signal = 1'b1;
        tick(30);
        @(negedge clk);
        check("post_reset_irq",   32'(hpd_irq),   32'd0);
        check("post_reset_count", 32'(irq_count), 32'd0);
        check("post_reset_drop",  32'(n_drop),    32'd2);
        check("post_reset_bad",   32'(n_bad),     32'd2);
        tick(100);
        @(negedge clk);
        check("post_reset_plugs",  32'(n_plug),     32'd3);
        check("post_reset_detect", 32'(hpd_detect), 32'd1);
        check("pulse_exclusive",   32'(n_multi),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
